dlatch_output_checker: RTL

//   Downstream consumer of the D-latch stage. Samples the latch stimulus (en, d) and its outputs (q, qb).

---
 rtl/dlatch_output_checker.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/dlatch_output_checker.sv
// Checks a D-latch's outputs against its stimulus: q follows d while open, q holds while closed,
// and qb is the complement of q. It flags violations and counts q toggles and error pulses.
module dlatch_output_checker #(
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             d,
  input  logic             q,
  input  logic             qb,
  input  logic             clr,
  output logic             err_compl,
  output logic             err_follow,
  output logic             err_hold,
  output logic             err_sticky,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRANSP = 2'd1,
    SETTLE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int              SC_W       = $clog2(SETTLE_CYC + 1);
  localparam logic [SC_W-1:0] SETTLE_MAX = SC_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  // Stage 1: raw samples of the latch interface.
  logic en_r_q, d_r_q, q_r_q, qb_r_q, valid_q;

  // Stage 2: checker state and registered outputs.
  state_t            state_q, state_d;
  logic [SC_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic              held_q, held_d;
  logic              last_q_q, last_q_d;
  logic              last_valid_q, last_valid_d;
  logic              err_compl_q, err_compl_d;
  logic              err_follow_q, err_follow_d;
  logic              err_hold_q, err_hold_d;
  logic              err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0]  toggle_cnt_q, toggle_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic              toggle_inc;
  logic [1:0]        n_pulses;
  logic [CNT_W:0]    err_sum;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the block can infer a latch.
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    held_d       = held_q;
    last_q_d     = last_q_q;
    last_valid_d = last_valid_q;
    err_compl_d  = 1'b0;
    err_follow_d = 1'b0;
    err_hold_d   = 1'b0;
    toggle_inc   = 1'b0;

    if (valid_q) begin
      err_compl_d  = (q_r_q == qb_r_q);
      toggle_inc   = last_valid_q && (q_r_q != last_q_q);
      last_q_d     = q_r_q;
      last_valid_d = 1'b1;

      if (state_q == SETTLE) begin
        if (!en_r_q) begin
          state_d = HOLD;
          held_d  = q_r_q;
        end else if (q_r_q == d_r_q) begin
          state_d = TRANSP;
        end else if (settle_cnt_q != SETTLE_MAX) begin
          // Counter freezes at SETTLE_MAX so a persistent mismatch reports once.
          settle_cnt_d = settle_cnt_q + 1'b1;
          err_follow_d = (settle_cnt_q + 1'b1 == SETTLE_MAX);
        end
      end else if (!en_r_q) begin
        err_hold_d = (state_q == HOLD) && (q_r_q != held_q);
        state_d    = HOLD;
        held_d     = q_r_q;
      end else if (q_r_q == d_r_q) begin
        state_d = TRANSP;
      end else begin
        state_d      = SETTLE;
        settle_cnt_d = SC_W'(1);
        err_follow_d = (SETTLE_CYC == 1);
      end
    end

    n_pulses = {1'b0, err_compl_d} + {1'b0, err_follow_d} + {1'b0, err_hold_d};
    err_sum  = {1'b0, err_cnt_q} + (CNT_W + 1)'(n_pulses);

    if (clr) begin
      toggle_cnt_d = '0;
      err_cnt_d    = '0;
      err_sticky_d = 1'b0;
    end else begin
      toggle_cnt_d = (toggle_inc && toggle_cnt_q != CNT_MAX) ? toggle_cnt_q + 1'b1 : toggle_cnt_q;
      err_cnt_d    = err_sum[CNT_W] ? CNT_MAX : err_sum[CNT_W-1:0];
      err_sticky_d = err_sticky_q | (n_pulses != 2'd0);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of order.
    if (!rst_n) begin
      en_r_q       <= 1'b0;
      d_r_q        <= 1'b0;
      q_r_q        <= 1'b0;
      qb_r_q       <= 1'b0;
      valid_q      <= 1'b0;
      state_q      <= IDLE;
      settle_cnt_q <= '0;
      held_q       <= 1'b0;
      last_q_q     <= 1'b0;
      last_valid_q <= 1'b0;
      err_compl_q  <= 1'b0;
      err_follow_q <= 1'b0;
      err_hold_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      toggle_cnt_q <= '0;
      err_cnt_q    <= '0;
    end else begin
      en_r_q       <= en;
      d_r_q        <= d;
      q_r_q        <= q;
      qb_r_q       <= qb;
      valid_q      <= 1'b1;
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      held_q       <= held_d;
      last_q_q     <= last_q_d;
      last_valid_q <= last_valid_d;
      err_compl_q  <= err_compl_d;
      err_follow_q <= err_follow_d;
      err_hold_q   <= err_hold_d;
      err_sticky_q <= err_sticky_d;
      toggle_cnt_q <= toggle_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign err_compl  = err_compl_q;
  assign err_follow = err_follow_q;
  assign err_hold   = err_hold_q;
  assign err_sticky = err_sticky_q;
  assign toggle_cnt = toggle_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign state      = state_q;

endmodule
